// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority channel mux.
package mux_pkg;

    // Arbitration modes selectable through the MODE parameter.
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Grant selection for N requesters: rotating search from ptr (round-robin) or
// lowest-index-wins (fixed priority). Purely combinational.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int MODE = MODE_RR,
    localparam int SW   = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    // Walk the request vector starting at the priority position, take the first hit.
    always_comb begin : search
        int            start;
        int            idx;
        logic [SW-1:0] idx_s;
        logic          found;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_s     = '0;
        start     = (MODE == MODE_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_s = idx[SW-1:0];
            if (en && !found && req[idx_s]) begin
                found        = 1'b1;
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n_w.sv
// N-channel, W-bit arbitrated mux with a single registered output stage.
// The output register doubles as a one-deep skid: a new beat is loaded only
// when the stage is empty or being drained this cycle.
module mux_rr_n_w
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = MODE_RR,
    localparam int SW   = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_sel,
    output logic          out_valid,
    input  logic          out_ready
);

    logic          load_en;
    logic          arb_en;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  sel_data;

    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    // The stage can take a beat when empty or when its current beat leaves now.
    assign load_en = !out_valid_q || out_ready;
    // Reset suppresses every grant so no channel sees a handshake during reset.
    assign arb_en  = load_en && !rst;

    rr_arbiter_n #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_ready  = grant;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

    // One-hot AND-OR select of the granted channel's data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*W +: W];
            end
        end
    end

    // Next-state: load on grant, go empty when nothing is offered, hold otherwise.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (|grant) begin
                out_data_d  = sel_data;
                out_sel_d   = grant_idx;
                out_valid_d = 1'b1;
                // Explicit wrap keeps ptr inside 0..N-1 for non-power-of-two N.
                ptr_d       = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; a held beat is simply dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_n_w.sv
// Directed bench for mux_rr_n_w: three instances (N=4 round-robin, N=3
// round-robin, N=4 fixed priority) driven one at a time; expected beats are
// queued when a grant is expected and compared when the output is consumed.
module tb_mux_rr_n_w;

    localparam logic [31:0] DATA4 = 32'hA3A2A1A0;
    localparam logic [23:0] DATA3 = 24'hA2A1A0;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] vld [3];
    logic       rdy [3];

    logic [3:0] ir0, ir2;
    logic [2:0] ir1;
    logic [7:0] od0, od1, od2;
    logic [1:0] os0, os1, os2;
    logic       ov0, ov1, ov2;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    mux_rr_n_w #(.N(4), .W(8), .MODE(0)) dut_rr4 (
        .clk(clk), .rst(rst), .in_data(DATA4), .in_valid(vld[0]), .in_ready(ir0),
        .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(rdy[0])
    );

    mux_rr_n_w #(.N(3), .W(8), .MODE(0)) dut_rr3 (
        .clk(clk), .rst(rst), .in_data(DATA3), .in_valid(vld[1][2:0]), .in_ready(ir1),
        .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(rdy[1])
    );

    mux_rr_n_w #(.N(4), .W(8), .MODE(1)) dut_fix4 (
        .clk(clk), .rst(rst), .in_data(DATA4), .in_valid(vld[2]), .in_ready(ir2),
        .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(rdy[2])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d, output logic [3:0] ir, output logic [7:0] od,
                          output logic [1:0] os, output logic ov);
        case (d)
            0:       begin ir = ir0;          od = od0; os = os0; ov = ov0; end
            1:       begin ir = {1'b0, ir1};  od = od1; os = os1; ov = ov1; end
            default: begin ir = ir2;          od = od2; os = os2; ov = ov2; end
        endcase
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Called at posedge+1: drive, check the pre-edge view, update scoreboard, advance one cycle.
    task automatic step(input int d, input logic [3:0] v, input logic r,
                        input logic [3:0] exp_rdy, input logic exp_ov, input string tag);
        logic [3:0] ir;
        logic [7:0] od;
        logic [1:0] os;
        logic       ov;
        beat_t      b;
        vld[d] = v;
        rdy[d] = r;
        #1;
        sample(d, ir, od, os, ov);
        chk({tag, " in_ready"}, {4'b0, ir}, {4'b0, exp_rdy});
        chk({tag, " out_valid"}, {7'b0, ov}, {7'b0, exp_ov});
        if (exp_ov && sb.size() > 0) begin
            b = sb[0];
            chk({tag, " out_data"}, od, b.data);
            chk({tag, " out_sel"}, {6'b0, os}, {6'b0, b.sel});
            if (r) void'(sb.pop_front());
        end
        if (exp_rdy != 4'b0) begin
            b.sel  = 2'(oh_idx(exp_rdy));
            b.data = 8'hA0 + 8'(oh_idx(exp_rdy));
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    // Hold rst for the given number of edges with every channel requesting.
    task automatic do_reset(input int d, input int cycles, input logic r, input string tag);
        logic [3:0] ir;
        logic [7:0] od;
        logic [1:0] os;
        logic       ov;
        rst    = 1'b1;
        vld[d] = 4'b1111;
        rdy[d] = r;
        #1;
        sample(d, ir, od, os, ov);
        chk({tag, " in_ready during rst"}, {4'b0, ir}, 8'h00);
        repeat (cycles) @(posedge clk);
        #1;
        sample(d, ir, od, os, ov);
        chk({tag, " out_valid after rst"}, {7'b0, ov}, 8'h00);
        chk({tag, " out_data after rst"}, od, 8'h00);
        chk({tag, " out_sel after rst"}, {6'b0, os}, 8'h00);
        rst    = 1'b0;
        vld[d] = 4'b0000;
        sb.delete();
    endtask

    initial begin
        logic [3:0] ir;
        logic [7:0] od;
        logic [1:0] os;
        logic       ov;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 4'b0000;
            rdy[i] = 1'b1;
        end
        @(posedge clk);
        #1;

        // N=4 round-robin: reset, then all channels valid.
        do_reset(0, 2, 1'b1, "rst4");
        step(0, 4'b1111, 1'b1, 4'b0001, 1'b0, "rr4_c0");
        step(0, 4'b1111, 1'b1, 4'b0010, 1'b1, "rr4_c1");
        step(0, 4'b1111, 1'b1, 4'b0100, 1'b1, "rr4_c2");
        step(0, 4'b1111, 1'b1, 4'b1000, 1'b1, "rr4_c3");
        step(0, 4'b1111, 1'b1, 4'b0001, 1'b1, "rr4_c0w");
        step(0, 4'b1111, 1'b1, 4'b0010, 1'b1, "rr4_c1w");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b1, "rr4_drain");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "rr4_idle");
        sample(0, ir, od, os, ov);
        chk("idle_hold out_data", od, 8'hA1);
        chk("idle_hold out_sel", {6'b0, os}, 8'h01);

        // Backpressure after the first beat.
        do_reset(0, 1, 1'b1, "rst4b");
        step(0, 4'b1111, 1'b1, 4'b0001, 1'b0, "bp_load");
        step(0, 4'b1111, 1'b0, 4'b0000, 1'b1, "bp_hold1");
        step(0, 4'b1111, 1'b0, 4'b0000, 1'b1, "bp_hold2");
        step(0, 4'b1111, 1'b0, 4'b0000, 1'b1, "bp_hold3");
        step(0, 4'b1111, 1'b1, 4'b0010, 1'b1, "bp_release");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b1, "bp_drain");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "bp_idle");

        // Sparse requests and wrap (ptr is 2 here).
        step(0, 4'b0100, 1'b1, 4'b0100, 1'b0, "sp_c2a");
        step(0, 4'b0100, 1'b1, 4'b0100, 1'b1, "sp_c2b");
        step(0, 4'b0100, 1'b1, 4'b0100, 1'b1, "sp_c2c");
        step(0, 4'b1010, 1'b1, 4'b1000, 1'b1, "sp_c3");
        step(0, 4'b1010, 1'b1, 4'b0010, 1'b1, "sp_c1");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b1, "sp_drain");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "sp_idle");

        // Reset while a beat is stalled; the beat is discarded and ch0 leads.
        step(0, 4'b1111, 1'b1, 4'b0100, 1'b0, "mr_load");
        step(0, 4'b1111, 1'b0, 4'b0000, 1'b1, "mr_hold");
        do_reset(0, 1, 1'b0, "mr_rst");
        step(0, 4'b1111, 1'b1, 4'b0001, 1'b0, "mr_c0");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b1, "mr_drain");
        step(0, 4'b0000, 1'b1, 4'b0000, 1'b0, "mr_idle");

        // N=3 round-robin wrap.
        do_reset(1, 2, 1'b1, "rst3");
        step(1, 4'b0111, 1'b1, 4'b0001, 1'b0, "rr3_c0");
        step(1, 4'b0111, 1'b1, 4'b0010, 1'b1, "rr3_c1");
        step(1, 4'b0111, 1'b1, 4'b0100, 1'b1, "rr3_c2");
        step(1, 4'b0111, 1'b1, 4'b0001, 1'b1, "rr3_c0w");
        step(1, 4'b0000, 1'b1, 4'b0000, 1'b1, "rr3_drain");
        step(1, 4'b0000, 1'b1, 4'b0000, 1'b0, "rr3_idle");

        // Fixed priority.
        do_reset(2, 2, 1'b1, "rstf");
        step(2, 4'b1111, 1'b1, 4'b0001, 1'b0, "fx_c0a");
        step(2, 4'b1111, 1'b1, 4'b0001, 1'b1, "fx_c0b");
        step(2, 4'b1111, 1'b1, 4'b0001, 1'b1, "fx_c0c");
        step(2, 4'b1110, 1'b1, 4'b0010, 1'b1, "fx_c1");
        step(2, 4'b0000, 1'b1, 4'b0000, 1'b1, "fx_drain");
        step(2, 4'b0000, 1'b1, 4'b0000, 1'b0, "fx_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
